// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch and load/store.
// One transaction in flight; fixed LSU priority with a starvation counter that forces an IFU win.
module mem_arbiter #(
    parameter int DW         = 64,
    parameter int MW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ifu_req,
    input  logic [DW-1:0] i_ifu_addr,
    output logic          o_ifu_gnt,
    output logic          o_ifu_rvalid,
    output logic [DW-1:0] o_ifu_rdata,
    input  logic          i_lsu_req,
    input  logic          i_lsu_wen,
    input  logic [DW-1:0] i_lsu_addr,
    input  logic [DW-1:0] i_lsu_wdata,
    input  logic [MW-1:0] i_lsu_wmask,
    output logic          o_lsu_gnt,
    output logic          o_lsu_rvalid,
    output logic [DW-1:0] o_lsu_rdata,
    output logic          o_mem_req,
    output logic          o_mem_wen,
    output logic [DW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic [MW-1:0] o_mem_wmask,
    input  logic          i_mem_gnt,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;        // 1 = LSU owns the transaction
    logic [3:0]    starve_q, starve_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_wen_q, mem_wen_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [MW-1:0] mem_wmask_q, mem_wmask_d;
    logic [DW-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DW-1:0] lsu_rdata_q, lsu_rdata_d;

    logic ifu_win, lsu_win, ifu_gnt, lsu_gnt, capture;

    // Arbitration is only live in IDLE; the IFU wins outright once it has lost STARVE_MAX times in a row.
    assign ifu_win = i_ifu_req & (~i_lsu_req | (starve_q == STARVE_LIM));
    assign lsu_win = i_lsu_req & ~ifu_win;
    assign ifu_gnt = (state_q == IDLE) & ~i_rst & ifu_win;
    assign lsu_gnt = (state_q == IDLE) & ~i_rst & lsu_win;
    assign capture = ((state_q == REQ) & i_mem_gnt & i_mem_rvalid) |
                     ((state_q == WAIT) & i_mem_rvalid);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ifu_gnt | lsu_gnt) state_d = REQ;
            REQ:     if (i_mem_gnt) state_d = i_mem_rvalid ? RESP : WAIT;
            WAIT:    if (i_mem_rvalid) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        if (ifu_gnt) begin
            owner_d     = 1'b0;
            starve_d    = '0;
            mem_req_d   = 1'b1;
            mem_wen_d   = 1'b0;
            mem_addr_d  = i_ifu_addr;
            mem_wdata_d = '0;
            mem_wmask_d = '0;
        end else if (lsu_gnt) begin
            owner_d     = 1'b1;
            if (i_ifu_req && starve_q < STARVE_LIM) starve_d = starve_q + 4'd1;
            mem_req_d   = 1'b1;
            mem_wen_d   = i_lsu_wen;
            mem_addr_d  = i_lsu_addr;
            mem_wdata_d = i_lsu_wdata;
            mem_wmask_d = i_lsu_wen ? i_lsu_wmask : '0;
        end
        if ((state_q == REQ) && i_mem_gnt) mem_req_d = 1'b0;
        // Stores return zero data so the LSU can treat every response uniformly.
        if (capture) begin
            if (owner_q) lsu_rdata_d = mem_wen_q ? '0 : i_mem_rdata;
            else         ifu_rdata_d = i_mem_rdata;
        end
    end

    always_comb begin
        o_ifu_gnt    = ifu_gnt;
        o_lsu_gnt    = lsu_gnt;
        o_ifu_rvalid = (state_q == RESP) & ~owner_q;
        o_lsu_rvalid = (state_q == RESP) & owner_q;
    end

    assign o_ifu_rdata = ifu_rdata_q;
    assign o_lsu_rdata = lsu_rdata_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_wen   = mem_wen_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wmask = mem_wmask_q;

endmodule
